// File: rtl/div_iter_pkg.sv
// Shared MDU definitions: divider FSM states and the M-extension divide funct3 codes.
package div_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // All four divide encodings share funct3[2]=1; bit 1 selects remainder, bit 0 unsigned.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dbit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            qbit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN:0]   diff;

  assign shifted = {rem_in, dbit};
  assign qbit    = (shifted >= {2'b00, divisor});
  // When the subtraction is kept the difference is below the divisor, so XLEN+1 bits suffice.
  assign diff    = shifted[XLEN:0] - {1'b0, divisor};
  assign rem_out = qbit ? diff : shifted[XLEN:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
import div_iter_pkg::*;

module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  input  logic            DivStartE,
  input  logic            FlushE,
  output logic            DivBusyE,
  output logic            DivDoneM,
  output logic [XLEN-1:0] ResultM
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_reg;
  logic [XLEN-1:0] a_reg;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [XLEN-1:0] b_reg;
  logic [XLEN:0]   rem_reg;
  logic [CW-1:0]   cnt_reg;
  logic            negq_reg;
  logic            negr_reg;
  logic            isrem_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [XLEN-1:0] result_reg;

  logic            op_signed;
  logic            op_valid;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   step_rem;
  logic            step_q;
  logic [XLEN-1:0] q_final;
  logic [XLEN-1:0] r_final;
  logic [XLEN-1:0] final_res;

  assign op_signed = ~Funct3E[0];
  assign op_valid  = is_div_op(Funct3E);
  assign div_zero  = (ForwardedSrcBE == '0);
  assign overflow  = op_signed && (ForwardedSrcAE == MOST_NEG) && (ForwardedSrcBE == '1);

  assign abs_a = (op_signed && ForwardedSrcAE[XLEN-1]) ? -ForwardedSrcAE : ForwardedSrcAE;
  assign abs_b = (op_signed && ForwardedSrcBE[XLEN-1]) ? -ForwardedSrcBE : ForwardedSrcBE;

  // Divide-by-zero wins over overflow; both results bypass sign fix-up.
  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = Funct3E[1] ? ForwardedSrcAE : '1;
    end else begin
      fast_res = Funct3E[1] ? '0 : ForwardedSrcAE;
    end
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_reg),
    .dbit    (a_reg[XLEN-1]),
    .divisor (b_reg),
    .rem_out (step_rem),
    .qbit    (step_q)
  );

  assign q_final   = {a_reg[XLEN-2:0], step_q};
  assign r_final   = step_rem[XLEN-1:0];
  assign final_res = isrem_reg ? (negr_reg ? -r_final : r_final)
                               : (negq_reg ? -q_final : q_final);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      negq_reg   <= 1'b0;
      negr_reg   <= 1'b0;
      isrem_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else if (FlushE) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (DivStartE && op_valid) begin
            a_reg     <= abs_a;
            b_reg     <= abs_b;
            rem_reg   <= '0;
            cnt_reg   <= CW'(XLEN - 1);
            negq_reg  <= op_signed & (ForwardedSrcAE[XLEN-1] ^ ForwardedSrcBE[XLEN-1]);
            negr_reg  <= op_signed & ForwardedSrcAE[XLEN-1];
            isrem_reg <= Funct3E[1];
            busy_reg  <= 1'b1;
            if (div_zero || overflow) begin
              state_reg  <= DONE;
              done_reg   <= 1'b1;
              result_reg <= fast_res;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          a_reg   <= q_final;
          rem_reg <= step_rem;
          if (cnt_reg == '0) begin
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            result_reg <= final_res;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign DivBusyE = busy_reg;
  assign DivDoneM = done_reg;
  assign ResultM  = result_reg;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table, random vectors and multi-cycle corner sequences.
module tb_div_iter;

  localparam int XLEN = 32;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          lat;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  funct3;
  logic        div_start;
  logic        flush;
  logic        div_busy;
  logic        div_done;
  logic [31:0] result;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;
  vec_t        vecs[16];

  div_iter #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .ForwardedSrcAE (src_a),
    .ForwardedSrcBE (src_b),
    .Funct3E        (funct3),
    .DivStartE      (div_start),
    .FlushE         (flush),
    .DivBusyE       (div_busy),
    .DivDoneM       (div_done),
    .ResultM        (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] e, input int lat);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.exp_res = e; v.lat = lat;
    return v;
  endfunction

  // Reference built on the language's own signed/unsigned division (truncates toward zero).
  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
      return f3[1] ? sa % sb : sa / sb;
    end
    return f3[1] ? a % b : a / b;
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one operation, then watch busy/done until idle. disturb>0 drives a competing
  // start (DIVU 100/7) at that cycle after acceptance.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int disturb);
    int lat, busy_cnt, done_cnt, done_lat;
    bit fin;
    @(negedge clk);
    funct3 = f3; src_a = a; src_b = b; div_start = 1'b1;
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1 div_start = 1'b0;
    lat = 0; busy_cnt = 0; done_cnt = 0; done_lat = -1; fin = 1'b0;
    while (!fin && lat < 100) begin
      @(negedge clk);
      lat++;
      if (disturb > 0 && lat == disturb + 1) div_start = 1'b0;
      if (div_busy) busy_cnt++;
      if (div_done) begin
        done_cnt++;
        done_lat = lat;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %h with empty scoreboard", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end
      if (disturb > 0 && lat == disturb) begin
        funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7; div_start = 1'b1;
      end
      if (!div_busy && !div_done) fin = 1'b1;
    end
    div_start = 1'b0;
    check("done_latency", 32'(done_lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (done_cnt == 0) exp_q.delete();
    last_res = exp_res;
    $display("op f3=%b a=%h b=%h expected=%h latency=%0d busy=%0d done=%0d",
             f3, a, b, exp_res, done_lat, busy_cnt, done_cnt);
  endtask

  // The block must stay idle with no done and an unchanged result for a while.
  task automatic watch_idle(input string name);
    int busy_seen, done_seen;
    busy_seen = 0; done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_busy) busy_seen++;
      if (div_done) done_seen++;
    end
    check({name, "_busy"}, 32'(busy_seen), 32'd0);
    check({name, "_done"}, 32'(done_seen), 32'd0);
    check({name, "_result"}, result, last_res);
    $display("seq %s busy_seen=%0d done_seen=%0d result=%h", name, busy_seen, done_seen, result);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    errors = 0; checks = 0; last_res = 32'd0;
    reset = 1'b0; flush = 1'b0; div_start = 1'b0;
    funct3 = 3'b000; src_a = 32'd0; src_b = 32'd0;

    vecs[0]  = mkv(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    vecs[1]  = mkv(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    vecs[2]  = mkv(3'b101, 32'd100,       32'd7,         32'd14,        33);
    vecs[3]  = mkv(3'b111, 32'd100,       32'd7,         32'd2,         33);
    vecs[4]  = mkv(3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
    vecs[5]  = mkv(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
    vecs[6]  = mkv(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    vecs[7]  = mkv(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    vecs[8]  = mkv(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
    vecs[9]  = mkv(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    vecs[10] = mkv(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    vecs[11] = mkv(3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 33);
    vecs[12] = mkv(3'b111, 32'hFFFF_FFFF, 32'h10,        32'hF,         33);
    vecs[13] = mkv(3'b100, 32'd0,         32'd5,         32'd0,         33);
    vecs[14] = mkv(3'b101, 32'd3,         32'hFFFF_FFFF, 32'd0,         33);
    vecs[15] = mkv(3'b111, 32'd3,         32'hFFFF_FFFF, 32'd3,         33);

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_done", 32'(div_done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].lat, 0);
    end

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'(4 + $urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) rb = -rb;
      run_op(rf3, ra, rb, model_res(rf3, ra, rb), model_lat(rf3, ra, rb), 0);
    end

    // Flush at iteration 10: no done, result keeps the previous value.
    @(negedge clk);
    funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    watch_idle("flush_mid");
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, 0);

    // Flush together with start in IDLE is not accepted.
    @(negedge clk);
    funct3 = 3'b100; src_a = 32'd50; src_b = 32'd5; div_start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin div_start = 1'b0; flush = 1'b0; end
    watch_idle("flush_start");

    // Undefined funct3 with start is not accepted.
    @(negedge clk);
    funct3 = 3'b010; src_a = 32'd50; src_b = 32'd5; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    watch_idle("bad_funct3");

    // Start while busy and start in DONE are both ignored.
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 5);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 33);

    // Asynchronous reset mid-operation clears outputs at once.
    @(negedge clk);
    funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7; div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", 32'(div_busy), 32'd0);
    check("midreset_done", 32'(div_done), 32'd0);
    check("midreset_result", result, 32'd0);
    $display("seq midreset busy=%b done=%b result=%h", div_busy, div_done, result);
    last_res = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    watch_idle("after_reset");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
